cache_refill_ctrl: RTL and testbench
====================================

# cache_refill_ctrl

Miss-refill controller directly downstream of the 32-bit direct-mapped cache. It accepts one miss address from the cache and fetches the whole block from backing memory, critical word first with wrap-around. It writes each returned word back into the cache data array and pulses completion so the cache can retry the access as a hit. It also keeps a saturating refill counter for hit/miss statistics in trace runs.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, word width
- WORDS_PER_BLOCK, 4, words per cache block; power of two, at least 2
- CNT_W, 16, refill counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- miss_valid  in  1  cache presents a miss
- miss_addr  in  ADDR_W  byte address of missing access
- miss_ready  out  1  controller idle and able to accept a miss
- mem_req  out  1  read request to backing memory
- mem_addr  out  ADDR_W  word-aligned request address
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid; responses in request order
- mem_rdata  in  DATA_W  read data
- fill_we  out  1  write one word into cache block
- fill_addr  out  ADDR_W  word-aligned address of the word being filled
- fill_data  out  DATA_W  data being filled
- crit_valid  out  1  the current fill word is the originally requested word
- fill_done  out  1  one-cycle pulse; block complete, tag may be marked valid
- protocol_err  out  1  sticky; unexpected memory response
- refill_count  out  CNT_W  completed refills, saturating

## Operation
- OFF_W = log2(WORDS_PER_BLOCK). Word offset = miss_addr[2 +: OFF_W]. Base = miss_addr with bits [OFF_W+1:0] cleared.
- FSM states and transitions:
  - IDLE -> FETCH on miss_valid && miss_ready.
  - FETCH -> DONE after the last response has been written.
  - DONE -> IDLE unconditionally after one cycle.
- miss_ready = (state == IDLE). The accept edge latches base and start offset and clears issue_cnt and resp_cnt.
- FETCH, issue side:
  - mem_req = (issue_cnt < WORDS_PER_BLOCK).
  - mem_addr = base | (((start + issue_cnt) mod WORDS_PER_BLOCK) << 2).
  - issue_cnt increments only on mem_req && mem_ready, so mem_addr stays stable while the request is stalled.
- FETCH, response side: each mem_rvalid is registered into fill_we, fill_data and fill_addr one cycle later. fill_addr uses the same wrap formula with resp_cnt. crit_valid = 1 only for resp_cnt == 0.
- Wrap-around: offset arithmetic is modulo WORDS_PER_BLOCK. For example, start 3 of 4 gives order 3,0,1,2.
- Issue and response can occur in the same cycle, and both counters advance independently.
- Responses are never stalled; the controller has no rdata backpressure.
- mem_rvalid outside FETCH, or after WORDS_PER_BLOCK responses: drop the data and set protocol_err. Never write the cache.
- refill_count increments on the fill_done cycle and holds at all-ones.
- miss_valid is ignored unless miss_ready is high. miss_addr is sampled only on accept.

## Timing
- Reset values: state IDLE, miss_ready 1 from the first cycle after reset, and all other outputs 0 (including protocol_err and refill_count).
- Cycle 0 = accept cycle. With mem_ready held at 1 and memory returning data one cycle after accept, WORDS_PER_BLOCK = 4 gives:
  - mem_req in cycles 1–4
  - mem_rvalid in cycles 2–5
  - fill_we in cycles 3–6
  - fill_done in cycle 7
  - miss_ready in cycle 8
- Back-to-back misses: the minimum gap between accepts is 8 cycles.
- Reset mid-FETCH returns to IDLE with the block abandoned and fill_done not pulsed. Stale responses arriving after reset set protocol_err.
- If rst and mem_rvalid are high in the same cycle, rst wins.

## Structure
- Package cache_pkg holds:
  - ADDR_W, DATA_W, WORDS_PER_BLOCK, OFF_W
  - refill_state_t enum: IDLE, FETCH, DONE
  - a function computing the wrapped word address from base, start and count
- The cache uses the same package for its offset and index split.
- One sub-module, refill_word_ptr: an OFF_W+1-bit counter with clear, increment and terminal flag. It is instantiated twice, once for issue_cnt and once for resp_cnt.

## Test plan
- miss_addr 0x0000_1008, mem_ready = 1, one-cycle memory latency -> fill_addr sequence 0x1008, 0x100C, 0x1000, 0x1004; crit_valid only on 0x1008; fill_done in cycle 7; refill_count = 1.
- mem_ready low for 3 cycles during the second request -> mem_addr holds at 0x1004 for 4 cycles; no duplicate or skipped address; fill_done delayed by 3 cycles.
- mem_rvalid pulsed in IDLE with rdata 0xDEAD_BEEF -> fill_we stays 0 and protocol_err goes high and stays high until rst.
- rst asserted in cycle 2 of a refill -> next cycle miss_ready = 1, fill_we = 0, fill_done never pulses; a new miss to 0x2000 completes normally.
- 65,540 back-to-back misses from an address-trace file with CNT_W = 16 -> refill_count saturates at 0xFFFF. The data filled for each block equals the memory model contents.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache geometry, refill FSM states and the wrapped word-address helper.
// Also used by the cache itself for its offset/index split.
package cache_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned OFF_W           = $clog2(WORDS_PER_BLOCK);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [OFF_W-1:0]  off_t;
    typedef logic [OFF_W:0]    ptr_t;

    localparam addr_t BLOCK_MASK = addr_t'((WORDS_PER_BLOCK * 4) - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } refill_state_t;

    // Offset arithmetic wraps naturally because off_t is exactly OFF_W bits wide.
    function automatic addr_t wrap_addr(input addr_t base, input off_t start, input ptr_t cnt);
        off_t off;
        off = start + cnt[OFF_W-1:0];
        return base | {{(ADDR_W - OFF_W - 2){1'b0}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/refill_word_ptr.sv
// Word pointer for one side of a block refill: counts 0..WORDS_PER_BLOCK and
// flags the terminal value, ignoring increments once terminal.
module refill_word_ptr
    import cache_pkg::*;
#(
    parameter int unsigned PTR_OFF_W = OFF_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [PTR_OFF_W:0] count,
    output logic               term
);

    localparam int unsigned PW = PTR_OFF_W + 1;

    // Block size is a power of two, so the MSB alone marks count == WORDS_PER_BLOCK.
    assign term = count[PTR_OFF_W];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !term) begin
            count <= count + PW'(1);
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-refill controller: fetches a whole block critical-word-first with wrap,
// writes each returned word into the cache and pulses completion.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              crit_valid,
    output logic              fill_done,
    output logic              protocol_err,
    output logic [CNT_W-1:0]  refill_count
);

    refill_state_t state;
    addr_t         base_q;
    off_t          start_q;
    ptr_t          issue_cnt;
    ptr_t          resp_cnt;
    logic          issue_term;
    logic          resp_term;
    logic          accept;
    logic          issue_fire;
    logic          resp_ok;

    assign accept     = miss_valid && miss_ready;
    assign issue_fire = mem_req && mem_ready;
    // Any response outside an open FETCH window is dropped and flagged.
    assign resp_ok    = mem_rvalid && (state == FETCH) && !resp_term;

    always_comb begin
        mem_req  = (state == FETCH) && !issue_term;
        mem_addr = '0;
        if (mem_req) begin
            mem_addr = wrap_addr(base_q, start_q, issue_cnt);
        end
    end

    refill_word_ptr #(.PTR_OFF_W(OFF_W)) u_issue_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .inc   (issue_fire),
        .count (issue_cnt),
        .term  (issue_term)
    );

    refill_word_ptr #(.PTR_OFF_W(OFF_W)) u_resp_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .inc   (resp_ok),
        .count (resp_cnt),
        .term  (resp_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            miss_ready   <= 1'b1;
            base_q       <= '0;
            start_q      <= '0;
            fill_we      <= 1'b0;
            fill_addr    <= '0;
            fill_data    <= '0;
            crit_valid   <= 1'b0;
            fill_done    <= 1'b0;
            protocol_err <= 1'b0;
            refill_count <= '0;
        end else begin
            fill_we    <= resp_ok;
            crit_valid <= resp_ok && (resp_cnt == '0);
            if (resp_ok) begin
                fill_addr <= wrap_addr(base_q, start_q, resp_cnt);
                fill_data <= mem_rdata;
            end
            if (mem_rvalid && !resp_ok) begin
                protocol_err <= 1'b1;
            end
            fill_done <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= FETCH;
                        miss_ready <= 1'b0;
                        base_q     <= miss_addr & ~BLOCK_MASK;
                        start_q    <= miss_addr[2 +: OFF_W];
                    end
                end
                // resp_term is seen the cycle the last word is on fill_we.
                FETCH: begin
                    if (resp_term) begin
                        state     <= DONE;
                        fill_done <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    miss_ready <= 1'b1;
                    if (refill_count != '1) begin
                        refill_count <= refill_count + CNT_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    miss_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_cache_refill_ctrl;

    localparam int unsigned WPB   = 4;
    localparam int unsigned CNT_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              miss_valid;
    logic [31:0]       miss_addr;
    logic              miss_ready;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              fill_we;
    logic [31:0]       fill_addr;
    logic [31:0]       fill_data;
    logic              crit_valid;
    logic              fill_done;
    logic              protocol_err;
    logic [CNT_W-1:0]  refill_count;

    cache_refill_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .miss_valid   (miss_valid),
        .miss_addr    (miss_addr),
        .miss_ready   (miss_ready),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .fill_we      (fill_we),
        .fill_addr    (fill_addr),
        .fill_data    (fill_data),
        .crit_valid   (crit_valid),
        .fill_done    (fill_done),
        .protocol_err (protocol_err),
        .refill_count (refill_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc    = 0;

    // Reference model of the refill in progress
    bit               m_active, m_fin, m_dp, m_perr;
    int               m_iss, m_rsp, m_start;
    logic [31:0]      m_base;
    logic [CNT_W-1:0] m_cnt;
    bit               pf_v, pf_c;
    logic [31:0]      pf_a, pf_d;

    // Backing memory responder
    typedef struct {
        logic [31:0] a;
        int          t;
    } rq_t;
    rq_t rq[$];

    bit          g_rst, g_miss, g_rnd, g_stall, g_spur;
    int          g_lat;
    logic [31:0] g_miss_addr;

    logic [31:0] fill_log[$];
    int          crit_n, done_n, done_cyc, hold_1004;
    logic [31:0] crit_a;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] blk_word(input int k);
        return m_base + 32'(((m_start + k) % WPB) * 4);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s cycle=%0d actual=timeout required=completion", name, cyc);
    endtask

    task automatic model_reset();
        m_active = 0; m_fin = 0; m_dp = 0; m_perr = 0;
        m_iss = 0; m_rsp = 0; m_start = 0; m_base = '0;
        m_cnt = '0; pf_v = 0; pf_c = 0; pf_a = '0; pf_d = '0;
    endtask

    task automatic check_outputs();
        bit exp_req;
        exp_req = m_active && (m_iss < WPB);
        chk("miss_ready", miss_ready, !m_active);
        chk("mem_req", mem_req, exp_req);
        chk("mem_addr", mem_addr, exp_req ? blk_word(m_iss) : 32'h0);
        chk("fill_we", fill_we, pf_v);
        if (pf_v) begin
            chk("fill_addr", fill_addr, pf_a);
            chk("fill_data", fill_data, pf_d);
        end
        chk("crit_valid", crit_valid, pf_v && pf_c);
        chk("fill_done", fill_done, m_dp);
        chk("protocol_err", protocol_err, m_perr);
        chk("refill_count", refill_count, m_cnt);
        if (fill_we) fill_log.push_back(fill_addr);
        if (crit_valid) begin crit_n++; crit_a = fill_addr; end
        if (fill_done) begin done_n++; done_cyc = cyc; end
        if (mem_req && mem_addr == 32'h1004) hold_1004++;
    endtask

    task automatic drive_and_model();
        bit          rv, old_act, old_fin, old_dp, nfin;
        logic [31:0] rd;
        rst        = g_rst;
        miss_valid = g_rnd ? ($urandom % 2 == 1) : g_miss;
        miss_addr  = (g_miss && !g_rnd) ? g_miss_addr : $urandom;
        mem_ready  = g_stall ? 1'b0 : (g_rnd ? ($urandom % 4 != 0) : 1'b1);
        rv = 0;
        rd = $urandom;
        if (g_spur) begin
            rv = 1;
            rd = 32'hDEAD_BEEF;
        end else if (rq.size() > 0 && rq[0].t <= cyc) begin
            rv = 1;
            rd = mem_word(rq[0].a);
            void'(rq.pop_front());
        end
        mem_rvalid = rv;
        mem_rdata  = rd;
        if (!g_rst && mem_req && mem_ready)
            rq.push_back('{mem_addr, cyc + 1 + (g_rnd ? int'($urandom_range(3, 0)) : g_lat)});

        if (g_rst) begin
            model_reset();
        end else begin
            old_act = m_active; old_fin = m_fin; old_dp = m_dp; nfin = 0;
            pf_v = 0; pf_c = 0;
            if (rv) begin
                if (old_act && m_rsp < WPB) begin
                    pf_v = 1;
                    pf_a = blk_word(m_rsp);
                    pf_d = mem_word(pf_a);
                    pf_c = (m_rsp == 0);
                    m_rsp++;
                    nfin = (m_rsp == WPB);
                end else begin
                    m_perr = 1;
                end
            end
            if (old_act && m_iss < WPB && mem_ready) m_iss++;
            m_fin = nfin;
            m_dp  = old_fin;
            if (old_dp) begin
                m_active = 0;
                if (m_cnt != '1) m_cnt++;
            end
            if (!old_act && miss_valid) begin
                m_active = 1;
                m_base   = miss_addr & ~32'(WPB * 4 - 1);
                m_start  = int'((miss_addr >> 2) % WPB);
                m_iss    = 0;
                m_rsp    = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        drive_and_model();
        cyc++;
    endtask

    task automatic start_miss(input logic [31:0] a);
        g_miss = 1; g_miss_addr = a; acc = cyc;
        step();
        g_miss = 0;
    endtask

    // Runs until the model is idle; optional ready-low window relative to accept.
    task automatic run_idle(input int budget, input int st_lo, input int st_hi);
        for (int i = 0; i < budget && m_active; i++) begin
            g_stall = (cyc - acc >= st_lo) && (cyc - acc <= st_hi);
            step();
        end
        g_stall = 0;
        if (m_active) timeout_fail("refill_timeout");
        step();
    endtask

    task automatic clear_obs();
        fill_log.delete();
        crit_n = 0; done_n = 0; done_cyc = -1; hold_1004 = 0;
    endtask

    task automatic do_reset();
        g_rst = 1; step(); g_rst = 0; step();
    endtask

    logic [31:0] exp_a[4];
    int          fills_before;

    initial begin
        rst = 1; miss_valid = 0; miss_addr = '0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        g_rst = 0; g_miss = 0; g_rnd = 0; g_stall = 0; g_spur = 0; g_lat = 0; g_miss_addr = '0;
        model_reset();
        clear_obs();
        repeat (2) @(posedge clk);

        // Reset state, then critical-word-first wrap from offset 2
        step();
        clear_obs();
        start_miss(32'h0000_1008);
        run_idle(40, -1, -2);
        exp_a = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
        chk("t1_fill_count", fill_log.size(), 4);
        for (int i = 0; i < 4 && i < fill_log.size(); i++) chk("t1_fill_order", fill_log[i], exp_a[i]);
        chk("t1_crit_count", crit_n, 1);
        chk("t1_crit_addr", crit_a, 32'h1008);
        chk("t1_done_cycle", done_cyc - acc, 7);
        chk("t1_refills", refill_count, 1);

        // Second request stalled for three cycles
        clear_obs();
        start_miss(32'h0000_1000);
        run_idle(40, 2, 4);
        exp_a = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        chk("t2_fill_count", fill_log.size(), 4);
        for (int i = 0; i < 4 && i < fill_log.size(); i++) chk("t2_fill_order", fill_log[i], exp_a[i]);
        chk("t2_hold_cycles", hold_1004, 4);
        chk("t2_done_cycle", done_cyc - acc, 10);
        chk("t2_refills", refill_count, 2);

        // Spurious response while idle
        fills_before = fill_log.size();
        g_spur = 1; step(); g_spur = 0;
        repeat (5) step();
        chk("t3_perr_sticky", protocol_err, 1);
        chk("t3_no_fill", fill_log.size() - fills_before, 0);
        do_reset();
        chk("t3_perr_cleared", protocol_err, 0);

        // Reset in cycle 2 of a refill: latency 0 collides with rst, latency 3 is stale
        for (int lat = 0; lat <= 3; lat += 3) begin
            clear_obs();
            g_lat = lat;
            start_miss(32'h0000_3004);
            step();
            g_rst = 1; step(); g_rst = 0;
            step();
            chk("t4_ready_after_rst", miss_ready, 1);
            chk("t4_no_fill_after_rst", fill_we, 0);
            repeat (8) step();
            chk("t4_no_done", done_n, 0);
            chk("t4_fill_count", fill_log.size(), 0);
            chk("t4_perr", protocol_err, (lat == 0) ? 0 : 1);
            g_lat = 0;
            do_reset();
            clear_obs();
            start_miss(32'h0000_2000);
            run_idle(40, -1, -2);
            exp_a = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
            chk("t4_new_fill_count", fill_log.size(), 4);
            for (int i = 0; i < 4 && i < fill_log.size(); i++) chk("t4_new_fill_order", fill_log[i], exp_a[i]);
            chk("t4_new_done", done_n, 1);
            chk("t4_new_refills", refill_count, 1);
        end

        // Randomized traffic until the counter saturates
        clear_obs();
        g_rnd = 1;
        for (int i = 0; i < 8000 && done_n < 40; i++) step();
        if (done_n < 40) timeout_fail("t5_refills");
        g_rnd = 0;
        run_idle(60, -1, -2);
        repeat (6) step();
        chk("t5_saturated", refill_count, 5'h1F);
        chk("t5_no_perr", protocol_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

endmodule
